// File: rtl/data_buffer_mc.sv
// rtl/data_buffer_mc.sv - multi-channel current capture buffer with timestamped samples
// Optional fb-sample decimation is compiled in with `define DATABUF_DECIM_EN.
module data_buffer_mc #(
    parameter int         ADDR_WIDTH   = 10,
    parameter int         NUM_CHAN     = 4,
    parameter logic [3:0] ADDR_MAIN    = 4'h1,
    parameter logic [3:0] OFF_DAC_CTRL = 4'h2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cur_fb_wen,
    input  logic [15:0] cur_fb,
    output logic [3:0]  chan,
    input  logic [15:0] reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wen,
    input  logic [15:0] reg_raddr,
    output logic [31:0] reg_rdata,
    output logic        reg_rwait,
    output logic [31:0] databuf_status,
    input  logic [31:0] ts
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] MAX_CHAN = 4'(NUM_CHAN);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;
    state_t state, state_nxt;

    logic [3:0]            chan_q;
    logic                  circ, done, wrapped, dropped;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  fb_wen_q, fb_edge, fb_take;
    logic                  cmd_req, fb_req, pend_vld, pend_vld_nxt, load_pend;
    logic [31:0]           cmd_word, fb_word, pend_word, wr_word, ram_q, status;
    logic                  wr_en, drop_now, at_last, collecting;
    logic                  ctrl_wr, start_ok, stop, cmd_hit;
    logic [6:0]            decim_field;
    logic [31:0]           mem [DEPTH];

    function automatic logic [31:0] mk_word(input logic src, input logic [31:0] t,
                                            input logic [15:0] d);
        return {src, |t[31:14], t[13:0], d};
    endfunction

    assign collecting = (state == S_COLLECT);
    assign ctrl_wr    = reg_wen && (reg_waddr == 16'h7800);
    assign stop       = ctrl_wr && reg_wdata[30];
    assign start_ok   = ctrl_wr && reg_wdata[31] && !reg_wdata[30] &&
                        (reg_wdata[27:24] != 4'd0) && (reg_wdata[27:24] <= MAX_CHAN);
    assign cmd_hit    = reg_wen && (reg_waddr[15:12] == ADDR_MAIN) &&
                        (reg_waddr[3:0] == OFF_DAC_CTRL) && (reg_waddr[7:4] == chan_q);
    assign fb_edge    = cur_fb_wen && !fb_wen_q;
    assign at_last    = (wr_addr == {ADDR_WIDTH{1'b1}});
    assign chan       = chan_q;

`ifdef DATABUF_DECIM_EN
    logic [6:0] decim, decim_cnt;
    logic       unused_wdata;
    assign unused_wdata = ^{reg_wdata[28], reg_wdata[23]};
    assign fb_take      = fb_edge && (decim_cnt == decim);
    assign decim_field  = decim;

    always_ff @(posedge clk) begin
        if (rst) begin
            decim     <= 7'd0;
            decim_cnt <= 7'd0;
        end else if (start_ok) begin
            decim     <= reg_wdata[22:16];
            decim_cnt <= 7'd0;
        end else if (collecting && fb_edge) begin
            decim_cnt <= (decim_cnt == decim) ? 7'd0 : decim_cnt + 7'd1;
        end
    end
`else
    logic unused_wdata;
    assign unused_wdata = ^{reg_wdata[28], reg_wdata[23:16]};
    assign fb_take      = fb_edge;
    assign decim_field  = 7'd0;
`endif

    // Write arbitration: cmd beats a waiting fb; a fb arriving while one waits is lost.
    always_comb begin
        wr_en        = 1'b0;
        wr_word      = cmd_word;
        pend_vld_nxt = 1'b0;
        load_pend    = 1'b0;
        drop_now     = 1'b0;
        state_nxt    = state;
        if (collecting && !stop && !start_ok) begin
            if (cmd_req) begin
                wr_en   = 1'b1;
                wr_word = cmd_word;
            end else if (pend_vld) begin
                wr_en   = 1'b1;
                wr_word = pend_word;
            end else if (fb_req) begin
                wr_en   = 1'b1;
                wr_word = fb_word;
            end
            drop_now     = fb_req && pend_vld;
            load_pend    = !pend_vld && cmd_req && fb_req;
            pend_vld_nxt = (pend_vld && cmd_req) || load_pend;
        end
        if (stop)
            state_nxt = S_IDLE;
        else if (start_ok)
            state_nxt = S_COLLECT;
        else if (wr_en && at_last && !circ)
            state_nxt = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            chan_q    <= 4'd1;
            circ      <= 1'b0;
            done      <= 1'b0;
            wrapped   <= 1'b0;
            dropped   <= 1'b0;
            wr_addr   <= '0;
            fb_wen_q  <= 1'b0;
            cmd_req   <= 1'b0;
            fb_req    <= 1'b0;
            pend_vld  <= 1'b0;
            cmd_word  <= '0;
            fb_word   <= '0;
            pend_word <= '0;
        end else begin
            state    <= state_nxt;
            fb_wen_q <= cur_fb_wen;
            cmd_word <= mk_word(1'b0, ts, reg_wdata[15:0]);
            fb_word  <= mk_word(1'b1, ts, cur_fb);
            if (stop || start_ok) begin
                cmd_req  <= 1'b0;
                fb_req   <= 1'b0;
                pend_vld <= 1'b0;
            end else begin
                cmd_req  <= collecting && cmd_hit;
                fb_req   <= collecting && fb_take;
                pend_vld <= pend_vld_nxt;
            end
            if (load_pend)
                pend_word <= fb_word;
            if (start_ok) begin
                chan_q  <= reg_wdata[27:24];
                circ    <= reg_wdata[29];
                wr_addr <= '0;
                done    <= 1'b0;
                wrapped <= 1'b0;
                dropped <= 1'b0;
            end else begin
                if (wr_en) begin
                    if (at_last) begin
                        if (circ) begin
                            wr_addr <= '0;
                            wrapped <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
                if (drop_now)
                    dropped <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_word;
        ram_q <= mem[reg_raddr[ADDR_WIDTH-1:0]];
    end

    assign status = {collecting, done, wrapped, circ, chan_q, dropped, decim_field,
                     4'd0, 12'(wr_addr)};
    assign databuf_status = status;
    assign reg_rwait      = (reg_raddr[15:12] == 4'h7) && !reg_raddr[11];
    assign reg_rdata      = reg_rwait ? ram_q :
                            (reg_raddr == 16'h7800) ? status : 32'd0;
endmodule

// File: tb/tb_data_buffer_mc.sv
// tb/tb_data_buffer_mc.sv - randomized self-checking bench for data_buffer_mc
module tb_data_buffer_mc;
    localparam int AW = 8;
    localparam int DEPTH = 256;
    localparam logic [3:0] A_MAIN  = 4'h1;
    localparam logic [3:0] OFF_DAC = 4'h2;
`ifdef DATABUF_DECIM_EN
    localparam bit DECIM_EN = 1'b1;
`else
    localparam bit DECIM_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, cur_fb_wen = 1'b0, reg_wen = 1'b0, reg_rwait;
    logic [15:0] cur_fb = '0, reg_waddr = '0, reg_raddr = '0;
    logic [31:0] reg_wdata = '0, ts = '0, reg_rdata, databuf_status;
    logic [3:0]  chan;
    int n_tests = 0, n_fail = 0;

    data_buffer_mc #(.ADDR_WIDTH(AW), .NUM_CHAN(4), .ADDR_MAIN(A_MAIN), .OFF_DAC_CTRL(OFF_DAC)) dut (
        .clk(clk), .rst(rst), .cur_fb_wen(cur_fb_wen), .cur_fb(cur_fb), .chan(chan),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .reg_rwait(reg_rwait),
        .databuf_status(databuf_status), .ts(ts)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered stream of sample words placed into a circular/one-shot array.
    logic [31:0] mram [DEPTH];
    bit          mvalid [DEPTH];
    int          m_state, m_addr, m_decim, m_fbcnt;
    bit          m_done, m_wrap, m_circ, m_drop, held_v, fb_prev;
    logic [3:0]  m_chan;
    logic [31:0] held_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        fb_prev = cur_fb_wen;
    endtask

    task automatic m_reset();
        m_state = 0; m_addr = 0; m_decim = 0; m_fbcnt = 0; m_chan = 4'd1;
        m_done = 0; m_wrap = 0; m_circ = 0; m_drop = 0; held_v = 0;
    endtask

    task automatic m_write(input logic [31:0] w);
        if (m_state != 1) return;
        mram[m_addr] = w;
        mvalid[m_addr] = 1'b1;
        if (m_addr == DEPTH - 1) begin
            if (m_circ) begin m_addr = 0; m_wrap = 1; end
            else begin m_done = 1; m_state = 2; end
        end else begin
            m_addr++;
        end
    endtask

    task automatic m_step(input bit c, input logic [31:0] cw, input bit f, input logic [31:0] fw);
        bit occ, take;
        if (m_state != 1) return;
        occ  = held_v;
        take = f;
        if (f && DECIM_EN) begin
            if (m_fbcnt == m_decim) m_fbcnt = 0;
            else begin m_fbcnt++; take = 0; end
        end
        if (c) m_write(cw);
        else if (held_v) begin m_write(held_w); held_v = 0; end
        if (take) begin
            if (occ) m_drop = 1;
            else if (c) begin held_v = 1; held_w = fw; end
            else m_write(fw);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {m_state == 1, m_done, m_wrap, m_circ, m_chan, m_drop, 7'(m_decim), 4'd0, 12'(m_addr)};
    endfunction

    task automatic drive_cycle(input bit do_cmd, input bit good_chan, input bit fb_lvl);
        logic [31:0] t, cw, fw;
        logic [3:0]  ch;
        bit          fb_rise;
        t  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 16383));
        ch = good_chan ? m_chan : m_chan + 4'd1;
        ts = t;
        reg_wen = do_cmd;
        reg_waddr = {A_MAIN, 4'h0, ch, OFF_DAC};
        reg_wdata = $urandom;
        cur_fb = 16'($urandom);
        cur_fb_wen = fb_lvl;
        fb_rise = fb_lvl && !fb_prev;
        cw = {1'b0, |t[31:14], t[13:0], reg_wdata[15:0]};
        fw = {1'b1, |t[31:14], t[13:0], cur_fb};
        cyc();
        reg_wen = 1'b0;
        m_step(do_cmd && good_chan, cw, fb_rise, fw);
    endtask

    task automatic ctrl_write(input bit start, input bit stp, input bit circ, input logic [3:0] ch,
                              input logic [6:0] dec);
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        reg_wen = 1'b1;
        reg_waddr = 16'h7800;
        reg_wdata = {start, stp, circ, 1'b0, ch, 1'b0, dec, 16'h0};
        cur_fb_wen = 1'b0;
        cyc();
        reg_wen = 1'b0;
        if (stp) begin
            m_state = 0; held_v = 0;
        end else if (start && ch >= 4'd1 && ch <= 4'd4) begin
            m_chan = ch; m_circ = circ; m_addr = 0; m_state = 1; held_v = 0;
            m_done = 0; m_wrap = 0; m_drop = 0; m_fbcnt = 0;
            m_decim = DECIM_EN ? int'(dec) : 0;
        end
    endtask

    task automatic chk_status(input string tag);
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        reg_raddr = 16'h7800;
        #1;
        check(tag, reg_rdata, m_status());
        check({tag, "_port"}, databuf_status, m_status());
        check({tag, "_rwait"}, {31'd0, reg_rwait}, 32'd0);
    endtask

    task automatic chk_ram(input string tag);
        cur_fb_wen = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mvalid[i]) begin
                reg_raddr = 16'h7000 | 16'(i);
                cyc();
                check(tag, reg_rdata, mram[i]);
            end
        end
        check({tag, "_rwait"}, {31'd0, reg_rwait}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_reset();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;

        chk_status("rst_status");
        check("rst_const", reg_rdata, 32'h0100_0000);
        reg_raddr = 16'h7900;
        #1;
        check("unmapped_rd", reg_rdata, 32'd0);

        ctrl_write(1, 0, 0, 4'd2, 7'd0);
        repeat (3) drive_cycle(1, 1, 0);
        drive_cycle(1, 0, 0);
        chk_status("cmd_status");
        check("cmd_addr", {20'd0, reg_rdata[11:0]}, 32'd3);
        check("chan_port", {28'd0, chan}, 32'd2);
        chk_ram("cmd_ram");

        ctrl_write(1, 0, 0, 4'd1, 7'd0);
        repeat (300) begin drive_cycle(0, 0, 1); drive_cycle(0, 0, 0); end
        chk_status("oneshot_status");
        check("oneshot_flags", {29'd0, reg_rdata[31:29]}, 32'd2);
        check("oneshot_addr", {20'd0, reg_rdata[11:0]}, 32'd255);
        chk_ram("oneshot_ram");

        ctrl_write(1, 0, 1, 4'd3, 7'd0);
        repeat (260) begin drive_cycle(0, 0, 1); drive_cycle(0, 0, 0); end
        chk_status("circ_status");
        check("circ_wrapped", {31'd0, reg_rdata[29]}, 32'd1);
        check("circ_addr", {20'd0, reg_rdata[11:0]}, 32'd4);
        chk_ram("circ_ram");

        ctrl_write(1, 0, 0, 4'd4, 7'd0);
        drive_cycle(1, 1, 1);
        drive_cycle(0, 0, 0);
        chk_status("same_status");
        check("same_nodrop", {31'd0, reg_rdata[23]}, 32'd0);
        chk_ram("same_ram");
        drive_cycle(1, 1, 1);
        drive_cycle(1, 1, 0);
        drive_cycle(0, 0, 1);
        chk_status("drop_status");
        check("drop_flag", {31'd0, reg_rdata[23]}, 32'd1);
        chk_ram("drop_ram");

        ctrl_write(1, 0, 0, 4'd1, 7'd3);
        repeat (12) begin drive_cycle(0, 0, 1); drive_cycle(0, 0, 0); end
        chk_status("decim_status");
        check("decim_addr", {20'd0, reg_rdata[11:0]}, DECIM_EN ? 32'd3 : 32'd12);
        chk_ram("decim_ram");
        ctrl_write(1, 0, 1, 4'd0, 7'd0);
        chk_status("chan0_ignored");
        ctrl_write(1, 0, 1, 4'd5, 7'd0);
        chk_status("chan5_ignored");

        ctrl_write(0, 1, 0, 4'd0, 7'd0);
        chk_status("stop_status");
        repeat (20) drive_cycle(1, 1, 1);
        chk_status("stop_idle");
        ctrl_write(1, 1, 0, 4'd2, 7'd0);
        chk_status("stop_wins");

        for (int r = 0; r < 4; r++) begin
            ctrl_write(1, 0, r[0], 4'($urandom_range(1, 4)), 7'd0);
            repeat (400) drive_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                                     $urandom_range(0, 1) == 1);
            chk_status("rand_status");
            chk_ram("rand_ram");
        end

        ctrl_write(1, 0, 1, 4'd2, 7'd0);
        repeat (30) drive_cycle($urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1);
        cur_fb_wen = 1'b0;
        reg_wen = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_reset();
        chk_status("midrst_status");
        check("midrst_const", reg_rdata, 32'h0100_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
